// File: rtl/fetch_queue_stage.sv
// rtl/fetch_queue_stage.sv - instruction fetch stage with DEPTH-entry prefetch FIFO
// Owns the fetch PC, issues sequential reads and buffers responses so fetch runs ahead of a frozen decode.

module fetch_queue_stage #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         freeze,
   input  logic                         branch_taken,
   input  logic [ADDR_W-1:0]            branch_address,
   output logic                         imem_req,
   output logic [ADDR_W-1:0]            imem_addr,
   input  logic [DATA_W-1:0]            imem_data,
   output logic                         out_valid,
   output logic [ADDR_W-1:0]            PC,
   output logic [DATA_W-1:0]            instruction,
   output logic [$clog2(DEPTH+1)-1:0]   fill_level
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W+1)'(DEPTH);

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] issue_addr;
   logic              inflight;
   logic [CNT_W-1:0]  count;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   logic [CNT_W:0] committed;
   logic           push;
   logic           pop;

   // Credit counts the outstanding read so a response always has a free slot.
   assign committed = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
   assign imem_req  = ~rst & ~branch_taken & (committed < DEPTH_LIM);
   assign imem_addr = fetch_pc;

   assign out_valid   = (count != '0);
   assign PC          = pc_mem[rd_ptr];
   assign instruction = data_mem[rd_ptr];
   assign fill_level  = count;

   assign push = inflight & ~branch_taken;
   assign pop  = out_valid & ~freeze & ~branch_taken;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc   <= RESET_PC;
         issue_addr <= '0;
         inflight   <= 1'b0;
         count      <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]   <= '0;
            data_mem[i] <= '0;
         end
      end else if (branch_taken) begin
         fetch_pc <= branch_address;
         inflight <= 1'b0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            fetch_pc   <= fetch_pc + PC_STEP;
            issue_addr <= fetch_pc;
         end
         if (push) begin
            pc_mem[wr_ptr]   <= issue_addr + PC_STEP;
            data_mem[wr_ptr] <= imem_data;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb/tb_fetch_queue_stage.sv - directed self-checking bench for fetch_queue_stage
// Memory returns its own address as data, so every head must satisfy instruction == PC - 4.

module tb_fetch_queue_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_address;

   logic        imem_req, imem_req2;
   logic [31:0] imem_addr, imem_addr2;
   logic [31:0] imem_data = '0, imem_data2 = '0;
   logic        out_valid, out_valid2;
   logic [31:0] pc_out, pc_out2;
   logic [31:0] instr, instr2;
   logic [2:0]  fill_level, fill_level2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fetch_queue_stage dut (
      .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
      .branch_address(branch_address), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_data(imem_data), .out_valid(out_valid), .PC(pc_out),
      .instruction(instr), .fill_level(fill_level)
   );

   fetch_queue_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
      .branch_address(branch_address), .imem_req(imem_req2), .imem_addr(imem_addr2),
      .imem_data(imem_data2), .out_valid(out_valid2), .PC(pc_out2),
      .instruction(instr2), .fill_level(fill_level2)
   );

   // Synchronous memories: word = address, valid one cycle after the request.
   always @(posedge clk) begin
      if (imem_req) imem_data <= imem_addr;
      if (imem_req2) imem_data2 <= imem_addr2;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic head(input string tag, input logic [31:0] pc);
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_pc"}, 64'(pc_out), 64'(pc));
      check({tag, "_instr"}, 64'(instr), 64'(pc - 32'd4));
   endtask

   initial begin
      rst = 1'b1;
      freeze = 1'b0;
      branch_taken = 1'b0;
      branch_address = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_fill", 64'(fill_level), 64'd0);
      check("rst_req", 64'(imem_req), 64'd0);
      check("rst_pc", 64'(pc_out), 64'd0);
      check("rst_instr", 64'(instr), 64'd0);

      // cycle 0
      rst = 1'b0;
      #1;
      check("c0_req", 64'(imem_req), 64'd1);
      check("c0_addr", 64'(imem_addr), 64'd0);
      check("wrap_addr0", 64'(imem_addr2), 64'hFFFF_FFF8);
      @(negedge clk);
      check("c1_valid", 64'(out_valid), 64'd0);
      check("c1_addr", 64'(imem_addr), 64'd4);
      check("wrap_addr1", 64'(imem_addr2), 64'hFFFF_FFFC);
      @(negedge clk);
      head("c2", 32'd4);
      check("c2_fill", 64'(fill_level), 64'd1);
      check("wrap_addr2", 64'(imem_addr2), 64'd0);
      check("wrap_pc0", 64'(pc_out2), 64'hFFFF_FFFC);
      @(negedge clk);
      head("c3", 32'd8);
      check("wrap_pc1", 64'(pc_out2), 64'd0);
      @(negedge clk);
      head("c4", 32'd12);
      check("wrap_pc2", 64'(pc_out2), 64'd4);
      check("wrap_instr2", 64'(instr2), 64'd0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         head("stream", 32'(16 + 4 * k));
         check("stream_fill", 64'(fill_level), 64'd1);
      end

      // freeze with head at 20
      freeze = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         head("frz_hold", 32'd20);
      end
      check("frz_fill", 64'(fill_level), 64'd4);
      check("frz_req", 64'(imem_req), 64'd0);
      freeze = 1'b0;
      #1;
      check("rel_req_full", 64'(imem_req), 64'd0);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         head("rel", 32'(20 + 4 * k));
      end

      // buffer three entries, then branch
      freeze = 1'b1;
      @(negedge clk);
      check("pre_br_fill", 64'(fill_level), 64'd3);
      branch_taken = 1'b1;
      branch_address = 32'h100;
      freeze = 1'b0;
      #1;
      check("br_req", 64'(imem_req), 64'd0);
      @(negedge clk);
      check("br1_fill", 64'(fill_level), 64'd0);
      check("br1_valid", 64'(out_valid), 64'd0);
      branch_taken = 1'b0;
      #1;
      check("br1_req", 64'(imem_req), 64'd1);
      check("br1_addr", 64'(imem_addr), 64'h100);
      @(negedge clk);
      check("br2_valid", 64'(out_valid), 64'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         head("br_stream", 32'(32'h104 + 4 * k));
      end

      // fill FIFO under freeze, then branch twice with freeze still high
      freeze = 1'b1;
      repeat (4) @(negedge clk);
      check("full_fill", 64'(fill_level), 64'd4);
      check("full_req", 64'(imem_req), 64'd0);
      branch_taken = 1'b1;
      branch_address = 32'h200;
      #1;
      check("fb_req0", 64'(imem_req), 64'd0);
      @(negedge clk);
      check("fb_fill", 64'(fill_level), 64'd0);
      check("fb_valid", 64'(out_valid), 64'd0);
      branch_address = 32'h300;
      #1;
      check("fb_req1", 64'(imem_req), 64'd0);
      @(negedge clk);
      branch_taken = 1'b0;
      #1;
      check("fb_req", 64'(imem_req), 64'd1);
      check("fb_addr", 64'(imem_addr), 64'h300);
      @(negedge clk);
      check("fb2_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      head("fb3", 32'h304);
      @(negedge clk);
      head("fb_hold", 32'h304);
      freeze = 1'b0;
      @(negedge clk);
      head("fb_go", 32'h308);
      @(negedge clk);
      head("fb_go2", 32'h30C);

      // reset for one cycle with a read outstanding
      rst = 1'b1;
      #1;
      check("mr_req", 64'(imem_req), 64'd0);
      @(negedge clk);
      check("mr_valid", 64'(out_valid), 64'd0);
      check("mr_fill", 64'(fill_level), 64'd0);
      check("mr_pc", 64'(pc_out), 64'd0);
      check("mr_instr", 64'(instr), 64'd0);
      rst = 1'b0;
      #1;
      check("mr_req0", 64'(imem_req), 64'd1);
      check("mr_addr0", 64'(imem_addr), 64'd0);
      @(negedge clk);
      check("mr1_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      head("mr2", 32'd4);
      @(negedge clk);
      head("mr3", 32'd8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_queue_stage.md
# fetch_queue_stage

Parametrised instruction-fetch stage for the ARM pipeline. It owns the fetch PC, issues sequential reads to a synchronous instruction memory, and buffers returned instructions in a DEPTH-entry FIFO. The FIFO lets fetch continue while decode is frozen. On a taken branch it flushes the buffered and in-flight instructions and redirects fetch. It sits between the instruction memory and the IF/ID register, replacing the single-register fetch path.

## Interface
- ADDR_W, 32, PC and address width
- DATA_W, 32, instruction width
- DEPTH, 4, FIFO entries; power of two, at least 2
- RESET_PC, 0, first fetch address after reset
- PC_STEP, 4, sequential increment
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- freeze  in  1  decode stall; head is not consumed while high
- branch_taken  in  1  redirect/flush request from EXE
- branch_address  in  ADDR_W  redirect target
- imem_req  out  1  read strobe to instruction memory
- imem_addr  out  ADDR_W  read address; equals fetch_pc
- imem_data  in  DATA_W  read data, valid exactly 1 cycle after imem_req
- out_valid  out  1  head entry valid
- PC  out  ADDR_W  head instruction address + PC_STEP (the codebase's IF PC convention)
- instruction  out  DATA_W  head instruction
- fill_level  out  clog2(DEPTH+1)  current FIFO occupancy

## Operation
- State:
  - fetch_pc register
  - inflight flag (a 1-cycle read is outstanding)
  - FIFO of {addr+PC_STEP, data} with read/write pointers wrapping modulo DEPTH
  - count register
- Pop: out_valid & ~freeze. Head advances at the clock edge.
- Issue: imem_req = ~rst & ~branch_taken & (count + inflight < DEPTH). Pop credit in the same cycle is not counted.
- On issue:
  - inflight <= 1 and the issued address is latched.
  - fetch_pc <= fetch_pc + PC_STEP, truncated to ADDR_W (wraps 0xFFFFFFFC -> 0x0 at defaults).
  - No issue: inflight <= 0.
- Response: when inflight is 1, imem_data plus the latched address + PC_STEP are pushed into the FIFO. Overflow is impossible by the credit rule.
- count update = count + push - pop. Simultaneous push and pop at any occupancy is legal.
- Branch (highest priority), in a cycle with branch_taken = 1:
  - The FIFO is cleared (count, pointers <= 0).
  - Any response arriving this cycle is discarded.
  - imem_req = 0, inflight <= 0, fetch_pc <= branch_address used unmodified.
  - Pop and push are ignored.
- branch_taken together with freeze: the branch wins and freeze has no effect.
- Consecutive branch_taken cycles: the last target wins; no fetch occurs until branch_taken drops.
- Outputs are driven from registered FIFO state only. imem_data has no combinational path to instruction.
- PC and instruction are don't-care when out_valid = 0. The bench checks them only while valid.

## Timing
- Reset values:
  - fetch_pc = RESET_PC, inflight = 0, count = 0
  - out_valid = 0, fill_level = 0, imem_req = 0 in the reset cycle
  - PC and instruction = 0
- Reset mid-operation: the same reset values are applied on the next edge. The in-flight response is dropped.
- First fetch:
  - cycle 0 (first cycle with rst low): req at RESET_PC
  - cycle 1: data pushed
  - cycle 2: out_valid = 1, PC = RESET_PC + 4
- Steady state with freeze low: one instruction per cycle, fill_level settles at 1.
- Branch asserted in cycle t:
  - cycle t+1: req at target
  - cycle t+3: out_valid with PC = target + 4
  - out_valid = 0 during t+1 and t+2
- Freeze held: the FIFO fills to DEPTH, then imem_req stays 0. After freeze drops, issue resumes the same cycle that count + inflight < DEPTH.

## Test plan
- Reset, then run with freeze = 0 and memory word = address:
  - out_valid rises in cycle 2 with PC = 4, instruction = 0x0.
  - After that, PC goes 8, 12, 16… one per cycle.
- Freeze for 10 cycles after the stream starts:
  - fill_level saturates at 4, imem_req = 0, and the head is held stable.
  - On release the stream continues with no gaps, skips or duplicates.
- branch_taken with branch_address = 0x100 while 3 entries are buffered:
  - fill_level = 0 and out_valid = 0 the next cycle.
  - The first valid PC is 0x104, three cycles after the branch.
  - No pre-branch instruction appears afterwards.
- branch_taken and freeze high together with the FIFO full:
  - The flush occurs and fetch restarts at the target once branch_taken drops.
- Set RESET_PC = 0xFFFFFFF8 and run 3 fetches:
  - Issued addresses are 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
  - The output PC sequence is 0xFFFFFFFC, 0x0, 0x4.
- Assert rst for 1 cycle mid-stream with an outstanding read:
  - All outputs return to reset values.
  - The stale response is never output.
  - Fetch restarts at RESET_PC.
